// File: rtl/spad_types_pkg.sv
// Shared scratchpad types and default geometry for the tile walker and its lane generator.
package spad_types_pkg;

    localparam int DEF_NUM_SCPADS    = 2;
    localparam int DEF_NUM_COLS      = 32;
    localparam int DEF_NUM_ROWS      = 32768;
    localparam int DEF_MAX_TILE_SIZE = 32;

    localparam int DEF_DIM_W   = $clog2(DEF_MAX_TILE_SIZE);
    localparam int DEF_ROW_W   = $clog2(DEF_NUM_ROWS);
    localparam int DEF_COL_W   = $clog2(DEF_NUM_COLS);
    localparam int DEF_SCPAD_W = (DEF_NUM_SCPADS > 1) ? $clog2(DEF_NUM_SCPADS) : 1;

    typedef logic [DEF_NUM_COLS*DEF_ROW_W-1:0] slot_mask_t;
    typedef logic [DEF_NUM_COLS*DEF_COL_W-1:0] shift_mask_t;
    typedef logic [DEF_NUM_COLS-1:0]           mask_t;

    typedef enum logic {
        ROW_WALK = 1'b0,
        COL_WALK = 1'b1
    } walk_mode_t;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } walker_state_t;

    typedef struct packed {
        logic [DEF_SCPAD_W-1:0] scpad_id;
        logic [DEF_ROW_W-1:0]   base_row;
        logic [DEF_DIM_W-1:0]   rows_m1;
        logic [DEF_DIM_W-1:0]   cols_m1;
        walk_mode_t             mode;
    } tile_req_t;

    // Width of a scratchpad id field; a single scratchpad still gets one bit.
    function automatic int scpad_id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scpad_skew_lane_gen.sv
// Per-bank slot / crossbar-lane / enable generation for one beat of a diagonally skewed tile.
module scpad_skew_lane_gen
    import spad_types_pkg::*;
#(
    parameter int NUM_COLS      = DEF_NUM_COLS,
    parameter int NUM_ROWS      = DEF_NUM_ROWS,
    parameter int MAX_TILE_SIZE = DEF_MAX_TILE_SIZE,
    localparam int DIM_W = $clog2(MAX_TILE_SIZE),
    localparam int ROW_W = $clog2(NUM_ROWS),
    localparam int COL_W = $clog2(NUM_COLS)
) (
    input  logic [ROW_W-1:0]          base_row,
    input  logic [DIM_W-1:0]          k,
    input  logic                      mode,
    input  logic [DIM_W-1:0]          rows_m1,
    input  logic [DIM_W-1:0]          cols_m1,
    output logic [NUM_COLS*ROW_W-1:0] slot_mask,
    output logic [NUM_COLS*COL_W-1:0] shift_mask,
    output logic [NUM_COLS-1:0]       mask
);

    // Bank b holds logical lane d = (b - k) mod NUM_COLS; the COL_W-bit subtract does the modulo.
    always_comb begin : p_lanes
        logic [COL_W-1:0] d;
        logic             en;
        slot_mask  = '0;
        shift_mask = '0;
        mask       = '0;
        d          = '0;
        en         = 1'b0;
        for (int b = 0; b < NUM_COLS; b++) begin
            d  = COL_W'(b) - COL_W'(k);
            en = (mode == COL_WALK) ? (d <= COL_W'(rows_m1)) : (d <= COL_W'(cols_m1));
            if (en) begin
                mask[b]                      = 1'b1;
                shift_mask[b*COL_W +: COL_W] = d;
                slot_mask[b*ROW_W +: ROW_W]  = (mode == COL_WALK) ? (base_row + ROW_W'(d))
                                                                  : (base_row + ROW_W'(k));
            end
        end
    end

endmodule

// File: rtl/scpad_tile_walker.sv
// Tile address walker: accepts one descriptor and streams one conflict-free beat per cycle.
//
// state  | meaning
// S_IDLE | no tile in flight, req_ready high
// S_RUN  | beat_valid high, walking beat_idx up to the tile's last index
module scpad_tile_walker
    import spad_types_pkg::*;
#(
    parameter int NUM_SCPADS    = DEF_NUM_SCPADS,
    parameter int NUM_COLS      = DEF_NUM_COLS,
    parameter int NUM_ROWS      = DEF_NUM_ROWS,
    parameter int MAX_TILE_SIZE = DEF_MAX_TILE_SIZE,
    localparam int DIM_W   = $clog2(MAX_TILE_SIZE),
    localparam int ROW_W   = $clog2(NUM_ROWS),
    localparam int COL_W   = $clog2(NUM_COLS),
    localparam int SCPAD_W = (NUM_SCPADS > 1) ? $clog2(NUM_SCPADS) : 1
) (
    input  logic                      CLK,
    input  logic                      nRST,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [SCPAD_W-1:0]        req_scpad_id,
    input  logic [ROW_W-1:0]          req_base_row,
    input  logic [DIM_W-1:0]          req_rows_m1,
    input  logic [DIM_W-1:0]          req_cols_m1,
    input  logic                      req_mode,
    input  logic                      abort,
    output logic                      beat_valid,
    input  logic                      beat_ready,
    output logic [SCPAD_W-1:0]        beat_scpad_id,
    output logic [NUM_COLS*ROW_W-1:0] beat_slot_mask,
    output logic [NUM_COLS*COL_W-1:0] beat_shift_mask,
    output logic [NUM_COLS-1:0]       beat_mask,
    output logic [DIM_W-1:0]          beat_idx,
    output logic                      beat_last,
    output logic                      busy
);

    if (MAX_TILE_SIZE > NUM_COLS) begin : g_chk_tile
        $error("scpad_tile_walker: MAX_TILE_SIZE must not exceed NUM_COLS");
    end
    if (NUM_ROWS < NUM_COLS) begin : g_chk_rows
        $error("scpad_tile_walker: NUM_ROWS must be at least NUM_COLS");
    end

    walker_state_t     state;
    logic [ROW_W-1:0]  base_q;
    logic [DIM_W-1:0]  rows_q;
    logic [DIM_W-1:0]  cols_q;
    logic              mode_q;

    logic              run;
    logic              beat_fire;
    logic              accept;
    logic [DIM_W-1:0]  last_idx;

    logic [ROW_W-1:0]  gen_base;
    logic [DIM_W-1:0]  gen_k;
    logic              gen_mode;
    logic [DIM_W-1:0]  gen_rows;
    logic [DIM_W-1:0]  gen_cols;
    logic [DIM_W-1:0]  gen_last_idx;
    logic              next_last;

    logic [NUM_COLS*ROW_W-1:0] gen_slot;
    logic [NUM_COLS*COL_W-1:0] gen_shift;
    logic [NUM_COLS-1:0]       gen_mask;

    assign run       = (state == S_RUN);
    assign busy      = run;
    assign beat_fire = run & beat_valid & beat_ready & ~abort;
    assign req_ready = run ? (beat_valid & beat_ready & beat_last & ~abort) : 1'b1;
    assign accept    = req_valid & req_ready;
    assign last_idx  = (mode_q == COL_WALK) ? cols_q : rows_q;

    // The generator always looks one beat ahead: either beat 0 of an incoming tile or the next beat.
    assign gen_base     = accept ? req_base_row : base_q;
    assign gen_k        = accept ? '0 : (beat_idx + DIM_W'(1));
    assign gen_mode     = accept ? req_mode : mode_q;
    assign gen_rows     = accept ? req_rows_m1 : rows_q;
    assign gen_cols     = accept ? req_cols_m1 : cols_q;
    assign gen_last_idx = (gen_mode == COL_WALK) ? gen_cols : gen_rows;
    assign next_last    = (gen_k == gen_last_idx);

    scpad_skew_lane_gen #(
        .NUM_COLS      (NUM_COLS),
        .NUM_ROWS      (NUM_ROWS),
        .MAX_TILE_SIZE (MAX_TILE_SIZE)
    ) u_lane_gen (
        .base_row   (gen_base),
        .k          (gen_k),
        .mode       (gen_mode),
        .rows_m1    (gen_rows),
        .cols_m1    (gen_cols),
        .slot_mask  (gen_slot),
        .shift_mask (gen_shift),
        .mask       (gen_mask)
    );

    // Walker FSM: abort beats any handshake; accepting on the last beat reloads with no bubble.
    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state           <= S_IDLE;
            base_q          <= '0;
            rows_q          <= '0;
            cols_q          <= '0;
            mode_q          <= 1'b0;
            beat_valid      <= 1'b0;
            beat_idx        <= '0;
            beat_last       <= 1'b0;
            beat_scpad_id   <= '0;
            beat_slot_mask  <= '0;
            beat_shift_mask <= '0;
            beat_mask       <= '0;
        end else if (run && abort) begin
            state           <= S_IDLE;
            beat_valid      <= 1'b0;
            beat_idx        <= '0;
            beat_last       <= 1'b0;
            beat_scpad_id   <= '0;
            beat_slot_mask  <= '0;
            beat_shift_mask <= '0;
            beat_mask       <= '0;
        end else if (accept) begin
            state           <= S_RUN;
            base_q          <= req_base_row;
            rows_q          <= req_rows_m1;
            cols_q          <= req_cols_m1;
            mode_q          <= req_mode;
            beat_valid      <= 1'b1;
            beat_idx        <= '0;
            beat_last       <= next_last;
            beat_scpad_id   <= req_scpad_id;
            beat_slot_mask  <= gen_slot;
            beat_shift_mask <= gen_shift;
            beat_mask       <= gen_mask;
        end else if (beat_fire) begin
            if (beat_last) begin
                state      <= S_IDLE;
                beat_valid <= 1'b0;
                beat_last  <= 1'b0;
            end else begin
                beat_idx        <= gen_k;
                beat_last       <= next_last;
                beat_slot_mask  <= gen_slot;
                beat_shift_mask <= gen_shift;
                beat_mask       <= gen_mask;
            end
        end
    end

endmodule
